// File: rtl/pll_reset_sequencer_pkg.sv
// Shared types and constants for the PLL reset sequencer.
// Contents: state_t (3-bit FSM encoding), SYNC_STAGES, LOSS_CNT_W.
package pll_reset_seq_pkg;

    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned LOSS_CNT_W  = 8;

    // Encodings are visible on state_o, so keep them fixed.
    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        FILTER    = 3'd1,
        HOLD      = 3'd2,
        RUN       = 3'd3,
        LOST      = 3'd4
    } state_t;

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// Bundle between the PLL/MCU side and the reset sequencer.
// lock, mcu_rst : async requests into the sequencer
// sys_rst, ready, state_o : sequencer status
// loss_cnt : lock-loss counter, present only with PLL_RESET_SEQ_LOSS_CNT_EN
interface pll_reset_sequencer_if;
    import pll_reset_seq_pkg::*;

    logic   lock;
    logic   mcu_rst;
    logic   sys_rst;
    logic   ready;
    state_t state_o;
`ifdef PLL_RESET_SEQ_LOSS_CNT_EN
    logic [LOSS_CNT_W-1:0] loss_cnt;

    modport master (output lock, output mcu_rst,
                    input sys_rst, input ready, input state_o, input loss_cnt);
    modport slave  (input lock, input mcu_rst,
                    output sys_rst, output ready, output state_o, output loss_cnt);
`else
    modport master (output lock, output mcu_rst,
                    input sys_rst, input ready, input state_o);
    modport slave  (input lock, input mcu_rst,
                    output sys_rst, output ready, output state_o);
`endif

endinterface

// File: rtl/pll_reset_sequencer_sync_2ff.sv
// Generic 1-bit synchronizer, SYNC_STAGES flops deep, synchronous active-low clear.
// Ports: clock, clr_n (sync clear), d (async in), q (synchronized out).
module sync_2ff
    import pll_reset_seq_pkg::*;
(
    input  logic clock,
    input  logic clr_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] ff;

    // Shift chain; q is the last stage.
    always_ff @(posedge clock) begin
        if (!clr_n) begin
            ff <= '0;
        end else begin
            ff <= {ff[SYNC_STAGES-2:0], d};
        end
    end

    assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Sequences the downstream active-high reset around PLL lock and MCU reset.
// Ports: clock, reset_n (sync, active-low), bus (slave side of
// pll_reset_sequencer_if: lock, mcu_rst in; sys_rst, ready, state_o out).
// Optional macro PLL_RESET_SEQ_LOSS_CNT_EN adds the saturating loss_cnt output.
module pll_reset_sequencer
    import pll_reset_seq_pkg::*;
#(
    parameter int unsigned LOCK_FILTER_CYCLES = 16,
    parameter int unsigned RESET_HOLD_CYCLES  = 1024,
    parameter int unsigned CNT_W              = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    pll_reset_sequencer_if.slave bus
);

    localparam logic [CNT_W-1:0] FILT_LOAD = CNT_W'(LOCK_FILTER_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(RESET_HOLD_CYCLES - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               lock_s, mcu_s;
    logic               sys_rst_q, ready_q;

    sync_2ff u_sync_lock (.clock(clock), .clr_n(reset_n), .d(bus.lock),    .q(lock_s));
    sync_2ff u_sync_mcu  (.clock(clock), .clr_n(reset_n), .d(bus.mcu_rst), .q(mcu_s));

    // Next-state and counter logic; lock loss takes priority over mcu_s.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            WAIT_LOCK: begin
                if (lock_s && !mcu_s) begin
                    state_d = FILTER;
                    cnt_d   = FILT_LOAD;
                end
            end
            FILTER: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                end else if (cnt_q == '0) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            HOLD: begin
                if (!lock_s) begin
                    state_d = LOST;
                end else if (mcu_s) begin
                    cnt_d = HOLD_LOAD;
                end else if (cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_d = LOST;
                end else if (mcu_s) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LOAD;
                end
            end
            LOST:    state_d = WAIT_LOCK;
            default: state_d = WAIT_LOCK;
        endcase
    end

    // State register; outputs decoded from next state so they move with it.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= WAIT_LOCK;
            cnt_q     <= '0;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sys_rst_q <= (state_d != RUN);
            ready_q   <= (state_d == RUN);
        end
    end

    assign bus.sys_rst = sys_rst_q;
    assign bus.ready   = ready_q;
    assign bus.state_o = state_q;

`ifdef PLL_RESET_SEQ_LOSS_CNT_EN
    logic [LOSS_CNT_W-1:0] loss_q;

    // LOST always exits after one cycle, so state_d == LOST marks an entry.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            loss_q <= '0;
        end else if (state_d == LOST && loss_q != {LOSS_CNT_W{1'b1}}) begin
            loss_q <= loss_q + LOSS_CNT_W'(1);
        end
    end

    assign bus.loss_cnt = loss_q;
`endif

endmodule
